// File: rtl/adc_seq_pkg.sv
// Shared definitions for the ADC sequencer.
//   ADC_DATA_W  : width of one conversion result
//   ADC_CH_W    : width of an ADC channel number
//   seq_state_t : sequencer FSM states
package adc_seq_pkg;

   localparam int unsigned ADC_DATA_W = 12;
   localparam int unsigned ADC_CH_W   = 5;

   typedef enum logic [1:0] {
      StIdle,
      StWaitTick,
      StSend,
      StWaitRsp
   } seq_state_t;

endpackage

// File: rtl/adc_seq_accum.sv
// Per-channel accumulator and averager.
// Ports:
//   clk_clk, reset_reset_n : clock, synchronous active-low reset
//   clear                  : discard the partial sum
//   add, sample            : add sample to the running sum
//   publish                : latch (sum incl. this cycle's add) >> AVG_LOG2, restart the sum
//   value                  : last published average
module adc_seq_accum
   import adc_seq_pkg::*;
#(
   parameter int unsigned AVG_LOG2 = 3
) (
   input  logic                  clk_clk,
   input  logic                  reset_reset_n,
   input  logic                  clear,
   input  logic                  add,
   input  logic [ADC_DATA_W-1:0] sample,
   input  logic                  publish,
   output logic [ADC_DATA_W-1:0] value
);

   // 2^AVG_LOG2 samples of ADC_DATA_W bits always fit in this width.
   localparam int unsigned AccW = ADC_DATA_W + AVG_LOG2;

   logic [AccW-1:0]       acc_q;
   logic [AccW-1:0]       acc_sum;
   logic [ADC_DATA_W-1:0] value_q;

   always_comb begin
      acc_sum = acc_q;
      if (add) begin
         acc_sum = acc_q + AccW'(sample);
      end
   end

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         acc_q   <= '0;
         value_q <= '0;
      end else if (clear) begin
         acc_q <= '0;
      end else if (publish) begin
         // Top bits of the sum are the truncated average.
         value_q <= acc_sum[AccW-1 -: ADC_DATA_W];
         acc_q   <= '0;
      end else begin
         acc_q <= acc_sum;
      end
   end

   assign value = value_q;

endmodule

// File: rtl/adc_sequencer.sv
// Avalon-ST initiator that periodically converts two ADC channels, averages
// 2^AVG_LOG2 rounds per channel and publishes the averages.
// Ports:
//   clk_clk, reset_reset_n    : clock, synchronous active-low reset
//   enable, err_clear         : sequencing enable, clear sticky error flags
//   cmd_*                     : command source towards the ADC core
//   rsp_*                     : response sink from the ADC core (SOP/EOP unused)
//   value_a, value_b          : averaged results, value_update strobes on change
//   err_timeout/mismatch/overrun : sticky error flags
module adc_sequencer
   import adc_seq_pkg::*;
#(
   parameter logic [ADC_CH_W-1:0] CH_A          = 5'd1,
   parameter logic [ADC_CH_W-1:0] CH_B          = 5'd2,
   parameter int unsigned         SAMPLE_PERIOD = 50000,
   parameter int unsigned         AVG_LOG2      = 3,
   parameter int unsigned         RSP_TIMEOUT   = 1024
) (
   input  logic                  clk_clk,
   input  logic                  reset_reset_n,
   input  logic                  enable,
   input  logic                  err_clear,
   output logic                  cmd_valid,
   output logic [ADC_CH_W-1:0]   cmd_channel,
   output logic                  cmd_startofpacket,
   output logic                  cmd_endofpacket,
   input  logic                  cmd_ready,
   input  logic                  rsp_valid,
   input  logic [ADC_CH_W-1:0]   rsp_channel,
   input  logic [ADC_DATA_W-1:0] rsp_data,
   input  logic                  rsp_startofpacket,
   input  logic                  rsp_endofpacket,
   output logic [ADC_DATA_W-1:0] value_a,
   output logic [ADC_DATA_W-1:0] value_b,
   output logic                  value_update,
   output logic                  err_timeout,
   output logic                  err_mismatch,
   output logic                  err_overrun
);

   localparam int unsigned PerW      = $clog2(SAMPLE_PERIOD);
   localparam int unsigned ToW       = $clog2(RSP_TIMEOUT + 1);
   localparam logic [6:0]  RoundLast = 7'((1 << AVG_LOG2) - 1);

   seq_state_t      state_q;
   logic [PerW-1:0] per_cnt_q;
   logic [ToW-1:0]  to_cnt_q;
   logic [6:0]      round_cnt_q;
   logic            pending_q;
   logic            cur_b_q;

   logic                  tick;
   logic [ADC_CH_W-1:0]   cur_ch;
   logic                  in_rsp;
   logic                  rsp_match;
   logic                  rsp_wrong;
   logic                  rsp_expire;
   logic                  sample_done;
   logic                  round_done;
   logic                  publish;
   logic                  acc_clear;
   logic                  add_a;
   logic [ADC_DATA_W-1:0] sample;

   logic unused_rsp_framing;
   assign unused_rsp_framing = rsp_startofpacket ^ rsp_endofpacket;

   always_comb begin
      tick        = enable && (per_cnt_q == PerW'(SAMPLE_PERIOD - 1));
      cur_ch      = cur_b_q ? CH_B : CH_A;
      in_rsp      = (state_q == StWaitRsp);
      rsp_match   = in_rsp && rsp_valid && (rsp_channel == cur_ch);
      rsp_wrong   = in_rsp && rsp_valid && (rsp_channel != cur_ch);
      // A matching beat on the last allowed cycle still wins over the timeout.
      rsp_expire  = in_rsp && !rsp_match && (to_cnt_q == ToW'(RSP_TIMEOUT - 1));
      sample_done = rsp_match || rsp_expire;
      round_done  = sample_done && cur_b_q;
      publish     = round_done && (round_cnt_q == RoundLast);
      add_a       = sample_done && !cur_b_q;
      acc_clear   = (state_q == StIdle);
      // On timeout the previously published value stands in for the lost sample.
      sample      = rsp_match ? rsp_data : (cur_b_q ? value_b : value_a);
   end

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         state_q           <= StIdle;
         per_cnt_q         <= '0;
         to_cnt_q          <= '0;
         round_cnt_q       <= '0;
         pending_q         <= 1'b0;
         cur_b_q           <= 1'b0;
         cmd_valid         <= 1'b0;
         cmd_channel       <= CH_A;
         cmd_startofpacket <= 1'b0;
         cmd_endofpacket   <= 1'b0;
         value_update      <= 1'b0;
         err_timeout       <= 1'b0;
         err_mismatch      <= 1'b0;
         err_overrun       <= 1'b0;
      end else begin
         // Period counter restarts whenever enable is low.
         if (!enable || tick) begin
            per_cnt_q <= '0;
         end else begin
            per_cnt_q <= per_cnt_q + 1'b1;
         end

         value_update <= publish;

         // Sticky flags: a new event wins over err_clear.
         if (tick && (pending_q || (state_q != StWaitTick))) begin
            err_overrun <= 1'b1;
         end else if (err_clear) begin
            err_overrun <= 1'b0;
         end
         if (rsp_wrong) begin
            err_mismatch <= 1'b1;
         end else if (err_clear) begin
            err_mismatch <= 1'b0;
         end
         if (rsp_expire) begin
            err_timeout <= 1'b1;
         end else if (err_clear) begin
            err_timeout <= 1'b0;
         end

         // Ticks arriving while busy are held, at most one deep.
         if (state_q != StWaitTick) begin
            pending_q <= pending_q | tick;
         end

         unique case (state_q)
            StIdle: begin
               pending_q   <= 1'b0;
               round_cnt_q <= '0;
               cur_b_q     <= 1'b0;
               if (enable) begin
                  state_q <= StWaitTick;
               end
            end
            StWaitTick: begin
               if (!enable) begin
                  state_q <= StIdle;
               end else if (tick || pending_q) begin
                  // If both are present one is consumed and the other stays pending.
                  pending_q         <= pending_q & tick;
                  state_q           <= StSend;
                  cur_b_q           <= 1'b0;
                  cmd_valid         <= 1'b1;
                  cmd_channel       <= CH_A;
                  cmd_startofpacket <= 1'b1;
                  cmd_endofpacket   <= 1'b1;
               end
            end
            StSend: begin
               if (cmd_ready) begin
                  cmd_valid         <= 1'b0;
                  cmd_startofpacket <= 1'b0;
                  cmd_endofpacket   <= 1'b0;
                  to_cnt_q          <= '0;
                  state_q           <= StWaitRsp;
               end
            end
            StWaitRsp: begin
               if (sample_done) begin
                  if (!cur_b_q) begin
                     cur_b_q           <= 1'b1;
                     state_q           <= StSend;
                     cmd_valid         <= 1'b1;
                     cmd_channel       <= CH_B;
                     cmd_startofpacket <= 1'b1;
                     cmd_endofpacket   <= 1'b1;
                  end else begin
                     round_cnt_q <= publish ? 7'd0 : round_cnt_q + 7'd1;
                     state_q     <= enable ? StWaitTick : StIdle;
                  end
               end else begin
                  to_cnt_q <= to_cnt_q + 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   adc_seq_accum #(
      .AVG_LOG2(AVG_LOG2)
   ) u_accum_a (
      .clk_clk      (clk_clk),
      .reset_reset_n(reset_reset_n),
      .clear        (acc_clear),
      .add          (add_a),
      .sample       (sample),
      .publish      (publish),
      .value        (value_a)
   );

   adc_seq_accum #(
      .AVG_LOG2(AVG_LOG2)
   ) u_accum_b (
      .clk_clk      (clk_clk),
      .reset_reset_n(reset_reset_n),
      .clear        (acc_clear),
      .add          (round_done),
      .sample       (sample),
      .publish      (publish),
      .value        (value_b)
   );

endmodule

// File: tb/tb_adc_sequencer.sv
// Directed bench for adc_sequencer: SAMPLE_PERIOD=16, AVG_LOG2=2, RSP_TIMEOUT=8.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_adc_sequencer;

   localparam logic [4:0] ChA = 5'd1;
   localparam logic [4:0] ChB = 5'd2;

   logic        clk;
   logic        reset_n;
   logic        enable;
   logic        err_clear;
   logic        cmd_valid;
   logic [4:0]  cmd_channel;
   logic        cmd_sop;
   logic        cmd_eop;
   logic        cmd_ready;
   logic        rsp_valid;
   logic [4:0]  rsp_channel;
   logic [11:0] rsp_data;
   logic        rsp_sop;
   logic        rsp_eop;
   logic [11:0] value_a;
   logic [11:0] value_b;
   logic        value_update;
   logic        err_timeout;
   logic        err_mismatch;
   logic        err_overrun;

   int n_cmp = 0;
   int n_err = 0;

   adc_sequencer #(
      .CH_A         (ChA),
      .CH_B         (ChB),
      .SAMPLE_PERIOD(16),
      .AVG_LOG2     (2),
      .RSP_TIMEOUT  (8)
   ) dut (
      .clk_clk          (clk),
      .reset_reset_n    (reset_n),
      .enable           (enable),
      .err_clear        (err_clear),
      .cmd_valid        (cmd_valid),
      .cmd_channel      (cmd_channel),
      .cmd_startofpacket(cmd_sop),
      .cmd_endofpacket  (cmd_eop),
      .cmd_ready        (cmd_ready),
      .rsp_valid        (rsp_valid),
      .rsp_channel      (rsp_channel),
      .rsp_data         (rsp_data),
      .rsp_startofpacket(rsp_sop),
      .rsp_endofpacket  (rsp_eop),
      .value_a          (value_a),
      .value_b          (value_b),
      .value_update     (value_update),
      .err_timeout      (err_timeout),
      .err_mismatch     (err_mismatch),
      .err_overrun      (err_overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Wait (bounded) for a command, return the number of falling edges waited.
   task automatic wait_cmd(input logic [4:0] exp_ch, input string tag, output int n);
      n = 0;
      while (cmd_valid !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_valid"}, 32'(cmd_valid), 32'd1);
      check({tag, "_ch"}, 32'(cmd_channel), 32'(exp_ch));
      check({tag, "_sop_eop"}, 32'({cmd_sop, cmd_eop}), 32'd3);
   endtask

   task automatic accept_cmd(input string tag);
      cmd_ready = 1'b1;
      @(negedge clk);
      cmd_ready = 1'b0;
      check({tag, "_drop"}, 32'(cmd_valid), 32'd0);
   endtask

   task automatic send_rsp(input logic [4:0] ch, input logic [11:0] data);
      rsp_valid   = 1'b1;
      rsp_channel = ch;
      rsp_data    = data;
      @(negedge clk);
      rsp_valid   = 1'b0;
      rsp_channel = '0;
      rsp_data    = '0;
   endtask

   task automatic do_round(input logic [11:0] a, input logic [11:0] b, input string tag);
      int n;
      wait_cmd(ChA, {tag, "_a"}, n);
      accept_cmd({tag, "_a"});
      send_rsp(ChA, a);
      wait_cmd(ChB, {tag, "_b"}, n);
      accept_cmd({tag, "_b"});
      send_rsp(ChB, b);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic seen;

      reset_n     = 1'b0;
      enable      = 1'b0;
      err_clear   = 1'b0;
      cmd_ready   = 1'b0;
      rsp_valid   = 1'b0;
      rsp_channel = '0;
      rsp_data    = '0;
      rsp_sop     = 1'b0;
      rsp_eop     = 1'b0;
      repeat (2) @(negedge clk);

      // Reset state
      check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
      check("rst_cmd_ch", 32'(cmd_channel), 32'(ChA));
      check("rst_sop_eop", 32'({cmd_sop, cmd_eop}), 32'd0);
      check("rst_values", 32'({value_a, value_b}), 32'd0);
      check("rst_update", 32'(value_update), 32'd0);
      check("rst_flags", 32'({err_timeout, err_mismatch, err_overrun}), 32'd0);

      // Basic averaging: first command after 16 clocks, update after 4 rounds
      reset_n = 1'b1;
      enable  = 1'b1;
      wait_cmd(ChA, "r1_a", n);
      check("first_tick_latency", 32'(n), 32'd16);
      accept_cmd("r1_a");
      send_rsp(ChA, 12'd100);
      wait_cmd(ChB, "r1_b", n);
      accept_cmd("r1_b");
      send_rsp(ChB, 12'd4095);
      check("r1_no_update", 32'(value_update), 32'd0);
      do_round(12'd104, 12'd4095, "r2");
      check("r2_no_update", 32'(value_update), 32'd0);
      do_round(12'd108, 12'd4095, "r3");
      check("r3_no_update", 32'(value_update), 32'd0);
      do_round(12'd112, 12'd4095, "r4");
      check("r4_update", 32'(value_update), 32'd1);
      check("r4_value_a", 32'(value_a), 32'd106);
      check("r4_value_b", 32'(value_b), 32'd4095);
      check("r4_flags", 32'({err_timeout, err_mismatch, err_overrun}), 32'd0);
      @(negedge clk);
      check("r4_update_one_cycle", 32'(value_update), 32'd0);

      // Backpressure: command held stable for 7 clocks without ready
      wait_cmd(ChA, "r5_a", n);
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         check("bp_valid_hold", 32'(cmd_valid), 32'd1);
         check("bp_ch_hold", 32'({cmd_channel, cmd_sop, cmd_eop}), 32'({ChA, 2'b11}));
      end
      accept_cmd("r5_a");
      send_rsp(ChA, 12'd200);
      wait_cmd(ChB, "r5_b", n);
      accept_cmd("r5_b");
      send_rsp(ChB, 12'h200);

      // Mismatched channel beat is discarded and flagged
      wait_cmd(ChA, "r6_a", n);
      accept_cmd("r6_a");
      send_rsp(5'd5, 12'hABC);
      check("mismatch_set", 32'(err_mismatch), 32'd1);
      send_rsp(ChA, 12'h010);
      wait_cmd(ChB, "r6_b", n);
      check("mismatch_continues", 32'(n), 32'd0);
      accept_cmd("r6_b");
      send_rsp(ChB, 12'h200);
      // Stray beat while waiting for a tick must be ignored
      send_rsp(ChA, 12'hFFF);
      do_round(12'd300, 12'h200, "r7");
      do_round(12'd400, 12'h200, "r8");
      check("r8_update", 32'(value_update), 32'd1);
      check("r8_value_a", 32'(value_a), 32'd229);
      check("r8_value_b", 32'(value_b), 32'h200);
      check("r8_mismatch_sticky", 32'(err_mismatch), 32'd1);
      check("r8_no_timeout_overrun", 32'({err_timeout, err_overrun}), 32'd0);
      err_clear = 1'b1;
      @(negedge clk);
      err_clear = 1'b0;
      check("mismatch_cleared", 32'(err_mismatch), 32'd0);

      // Timeout on channel B substitutes the published value 0x200
      wait_cmd(ChA, "r9_a", n);
      accept_cmd("r9_a");
      send_rsp(ChA, 12'd1000);
      wait_cmd(ChB, "r9_b", n);
      accept_cmd("r9_b");
      n = 0;
      while (err_timeout !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("timeout_latency", 32'(n), 32'd8);
      err_clear = 1'b1;
      @(negedge clk);
      err_clear = 1'b0;
      check("timeout_cleared", 32'(err_timeout), 32'd0);
      do_round(12'd1001, 12'h100, "r10");
      do_round(12'd1002, 12'h100, "r11");
      do_round(12'd1003, 12'h100, "r12");
      check("r12_update", 32'(value_update), 32'd1);
      check("r12_value_a_trunc", 32'(value_a), 32'd1001);
      check("r12_value_b_subst", 32'(value_b), 32'h140);

      // Overrun: 36-clock stall spans two ticks, only one round is queued
      wait_cmd(ChA, "r13_a", n);
      repeat (36) @(negedge clk);
      check("r13_hold_valid", 32'(cmd_valid), 32'd1);
      check("overrun_set", 32'(err_overrun), 32'd1);
      accept_cmd("r13_a");
      send_rsp(ChA, 12'd50);
      wait_cmd(ChB, "r13_b", n);
      accept_cmd("r13_b");
      send_rsp(ChB, 12'd60);
      wait_cmd(ChA, "r14_a", n);
      check("pending_round_latency", 32'(n), 32'd1);
      accept_cmd("r14_a");
      send_rsp(ChA, 12'd70);
      wait_cmd(ChB, "r14_b", n);
      accept_cmd("r14_b");
      send_rsp(ChB, 12'd80);
      wait_cmd(ChA, "r15_a", n);
      check("single_pending_only", 32'(n), 32'd3);

      // Enable drops in SEND: command completes, round finishes, then idle
      enable = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("send_hold_disabled", 32'(cmd_valid), 32'd1);
      end
      accept_cmd("r15_a");
      send_rsp(ChA, 12'd90);
      wait_cmd(ChB, "r15_b", n);
      check("round_finishes_disabled", 32'(n), 32'd0);
      accept_cmd("r15_b");
      send_rsp(ChB, 12'd100);
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (cmd_valid !== 1'b0) seen = 1'b1;
      end
      check("idle_no_cmd", 32'(seen), 32'd0);
      check("idle_value_a_kept", 32'(value_a), 32'd1001);
      check("idle_value_b_kept", 32'(value_b), 32'h140);

      // Re-enable: partial rounds were discarded, fresh group of 4
      enable = 1'b1;
      wait_cmd(ChA, "r16_a", n);
      check("reenable_latency", 32'(n), 32'd16);
      accept_cmd("r16_a");
      send_rsp(ChA, 12'd8);
      wait_cmd(ChB, "r16_b", n);
      accept_cmd("r16_b");
      send_rsp(ChB, 12'd12);
      check("r16_no_update", 32'(value_update), 32'd0);
      do_round(12'd8, 12'd12, "r17");
      do_round(12'd8, 12'd12, "r18");
      do_round(12'd8, 12'd12, "r19");
      check("r19_update", 32'(value_update), 32'd1);
      check("r19_value_a", 32'(value_a), 32'd8);
      check("r19_value_b", 32'(value_b), 32'd12);

      // Reset while waiting for the channel B response
      wait_cmd(ChA, "r20_a", n);
      accept_cmd("r20_a");
      send_rsp(ChA, 12'd8);
      wait_cmd(ChB, "r20_b", n);
      accept_cmd("r20_b");
      reset_n = 1'b0;
      @(negedge clk);
      check("mid_rst_cmd_valid", 32'(cmd_valid), 32'd0);
      check("mid_rst_cmd_ch", 32'(cmd_channel), 32'(ChA));
      check("mid_rst_values", 32'({value_a, value_b}), 32'd0);
      check("mid_rst_update", 32'(value_update), 32'd0);
      check("mid_rst_flags", 32'({err_timeout, err_mismatch, err_overrun}), 32'd0);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);
      check("post_rst_idle", 32'(cmd_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
